// File: rtl/spi_sd_master_if.sv
// CPU bus connection for the SD-card SPI master.
// The CPU side drives the select, address and write data; the peripheral side drives the acknowledge and read data.
interface spi_sd_master_if;
    logic        cs;
    logic [31:0] bus_addr;
    logic [31:0] bus_wr_val;
    logic [3:0]  bus_bytesel;
    logic        bus_ack;
    logic [31:0] bus_data;

    modport master (
        output cs,
        output bus_addr,
        output bus_wr_val,
        output bus_bytesel,
        input  bus_ack,
        input  bus_data
    );

    modport slave (
        input  cs,
        input  bus_addr,
        input  bus_wr_val,
        input  bus_bytesel,
        output bus_ack,
        output bus_data
    );
endinterface

// File: rtl/spi_sd_master.sv
// SPI mode-0 master for the SD card slot.
// Each DATA write sends one byte, MSB first. The SCLK divider is programmable, and software polls a busy flag.
module spi_sd_master #(
    parameter int                   DIV_WIDTH = 8,
    parameter logic [DIV_WIDTH-1:0] DIV_RESET = 8'd99
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_sd_master_if.slave   bus,
    output logic             sd_sclk,
    output logic             sd_mosi,
    input  logic             sd_miso,
    output logic             sd_cs_n
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_CLKDIV = 2'd2;

    state_t               state_r;
    logic [7:0]           shift_r;
    logic [7:0]           rx_r;
    logic [2:0]           bitcnt_r;
    logic [DIV_WIDTH-1:0] cnt_r;
    logic [DIV_WIDTH-1:0] div_r;
    logic                 busy_r;
    logic                 sclk_r;
    logic                 mosi_r;
    logic                 cs_n_r;
    logic                 ack_r;
    logic [31:0]          data_r;

    logic [1:0]           reg_sel_s;
    logic                 is_wr_s;
    logic                 stall_s;
    logic                 accept_s;
    logic                 start_s;
    logic [31:0]          rd_data_s;
    logic [7:0]           shift_nx_s;
    logic                 first_high_s;
    logic                 bus_unused_s;

    assign bus_unused_s = &{1'b0, bus.bus_addr[31:4], bus.bus_addr[1:0], bus.bus_wr_val[31:8]};

    // Decode the bus access, apply the busy stall, and build the read mux.
    always_comb begin
        reg_sel_s    = bus.bus_addr[3:2];
        is_wr_s      = (bus.bus_bytesel != 4'b0000);
        shift_nx_s   = {shift_r[6:0], sd_miso};
        // The counter is reloaded with the divisor on entry, so this marks the first cycle of a phase.
        first_high_s = (cnt_r == div_r);
        stall_s      = 1'b0;
        if (busy_r) begin
            if ((reg_sel_s == REG_CTRL) && !is_wr_s) begin
                stall_s = 1'b0;
            end else begin
                stall_s = 1'b1;
            end
        end else begin
            stall_s = 1'b0;
        end
        accept_s = bus.cs && !ack_r && !stall_s;
        start_s  = accept_s && is_wr_s && (reg_sel_s == REG_DATA);
        case (reg_sel_s)
            REG_DATA:   rd_data_s = {24'd0, rx_r};
            REG_CTRL:   rd_data_s = {30'd0, busy_r, cs_n_r};
            REG_CLKDIV: rd_data_s = {{(32-DIV_WIDTH){1'b0}}, div_r};
            default:    rd_data_s = 32'd0;
        endcase
    end

    // Drive the bus acknowledge and read data, and update the software-written registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_r  <= 1'b0;
            data_r <= 32'd0;
            cs_n_r <= 1'b1;
            div_r  <= DIV_RESET;
        end else if (accept_s) begin
            ack_r  <= 1'b1;
            data_r <= is_wr_s ? 32'd0 : rd_data_s;
            if (is_wr_s) begin
                case (reg_sel_s)
                    REG_CTRL:   cs_n_r <= bus.bus_wr_val[0];
                    REG_CLKDIV: div_r  <= bus.bus_wr_val[DIV_WIDTH-1:0];
                    default:    ;
                endcase
            end
        end else begin
            ack_r  <= 1'b0;
            data_r <= 32'd0;
        end
    end

    // Sequence one byte on the SPI pins, holding each SCLK half-period for CLKDIV+1 cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            shift_r  <= 8'd0;
            rx_r     <= 8'hFF;
            bitcnt_r <= 3'd0;
            cnt_r    <= {DIV_WIDTH{1'b0}};
            busy_r   <= 1'b0;
            sclk_r   <= 1'b0;
            mosi_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        state_r  <= ST_LOW;
                        shift_r  <= bus.bus_wr_val[7:0];
                        bitcnt_r <= 3'd7;
                        cnt_r    <= div_r;
                        busy_r   <= 1'b1;
                        sclk_r   <= 1'b0;
                        mosi_r   <= bus.bus_wr_val[7];
                    end else begin
                        state_r <= ST_IDLE;
                        sclk_r  <= 1'b0;
                        mosi_r  <= 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt_r == {DIV_WIDTH{1'b0}}) begin
                        state_r <= ST_HIGH;
                        cnt_r   <= div_r;
                        sclk_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - DIV_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    if (first_high_s) begin
                        shift_r <= shift_nx_s;
                    end
                    if (cnt_r == {DIV_WIDTH{1'b0}}) begin
                        sclk_r <= 1'b0;
                        cnt_r  <= div_r;
                        // With CLKDIV=0 the sample and the phase end share one cycle, so use the shifted value.
                        if (bitcnt_r != 3'd0) begin
                            state_r  <= ST_LOW;
                            bitcnt_r <= bitcnt_r - 3'd1;
                            mosi_r   <= first_high_s ? shift_nx_s[7] : shift_r[7];
                        end else begin
                            state_r <= ST_DONE;
                            mosi_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            rx_r    <= first_high_s ? shift_nx_s : shift_r;
                        end
                    end else begin
                        cnt_r <= cnt_r - DIV_WIDTH'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sclk_r  <= 1'b0;
                    mosi_r  <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bus_ack  = ack_r;
    assign bus.bus_data = data_r;
    assign sd_sclk      = sclk_r;
    assign sd_mosi      = mosi_r;
    assign sd_cs_n      = cs_n_r;

endmodule

// File: tb/tb_spi_sd_master.sv
// Scoreboard bench for spi_sd_master: bus responses and SPI bytes are predicted from register-level rules
// and checked by monitors that run independently of the stimulus.
module tb_spi_sd_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sd_sclk, sd_mosi, sd_miso, sd_cs_n;

    spi_sd_master_if bus ();

    spi_sd_master dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sd_sclk (sd_sclk),
        .sd_mosi (sd_mosi),
        .sd_miso (sd_miso),
        .sd_cs_n (sd_cs_n)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] mon_exp;
    logic [7:0]  mon_tx;

    // reference model state
    logic [7:0]  model_rx;
    logic        model_cs_n;
    int          model_div;
    logic        loopback = 1'b1;
    logic [7:0]  slave_byte = 8'h00;

    int          cyc = 0;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          fall_base = 0;
    int          rise_cyc = 0;
    int          fall_cyc = 0;
    int          bit_n = 0;
    logic [7:0]  mosi_byte = 8'h00;
    logic        sclk_prev = 1'b0;
    logic [2:0]  slave_idx;

    // The simulated card shifts out its byte MSB first, advancing after each SCLK fall.
    assign slave_idx = 3'(fall_cnt - fall_base);
    assign sd_miso   = loopback ? sd_mosi : slave_byte[3'd7 - slave_idx];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: bus acks against the scoreboard, SCLK timing, and bytes shifted out on MOSI.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            bit_n = 0;
            tx_q.delete();
        end else begin
            if (bus.bus_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: got data %0h expected no ack", bus.bus_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (bus.bus_data !== mon_exp) begin
                        errors++;
                        $display("FAIL bus_data: got %0h expected %0h", bus.bus_data, mon_exp);
                    end
                end
            end else if (bus.bus_data !== 32'd0) begin
                errors++;
                $display("FAIL idle_bus_data: got %0h expected 0", bus.bus_data);
            end
            if (sd_sclk && !sclk_prev) begin
                rise_cnt++;
                if (bit_n != 0) chk("sclk_low_width", 32'(cyc - fall_cyc), 32'(model_div + 1));
                rise_cyc  = cyc;
                mosi_byte = {mosi_byte[6:0], sd_mosi};
                bit_n++;
                if (bit_n == 8) begin
                    bit_n = 0;
                    checks++;
                    if (tx_q.size() == 0) begin
                        errors++;
                        $display("FAIL mosi_byte: got %0h expected no transfer", mosi_byte);
                    end else begin
                        mon_tx = tx_q.pop_front();
                        if (mosi_byte !== mon_tx) begin
                            errors++;
                            $display("FAIL mosi_byte: got %0h expected %0h", mosi_byte, mon_tx);
                        end
                    end
                end
            end
            if (!sd_sclk && sclk_prev) begin
                fall_cnt++;
                fall_cyc = cyc;
                chk("sclk_high_width", 32'(cyc - rise_cyc), 32'(model_div + 1));
            end
        end
        sclk_prev = sd_sclk;
    end

    task automatic access(input logic [1:0] a, input logic wr, input logic [31:0] v,
                          input logic [31:0] exp, output int lat);
        bus.cs          = 1'b1;
        bus.bus_addr    = {28'd0, a, 2'b00};
        bus.bus_wr_val  = v;
        bus.bus_bytesel = wr ? 4'hF : 4'h0;
        exp_q.push_back(exp);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!bus.bus_ack && lat < 3000);
        if (!bus.bus_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack after %0d cycles expected ack", lat);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        bus.cs          = 1'b0;
        bus.bus_bytesel = 4'h0;
    endtask

    task automatic start_xfer(input logic [7:0] tx, input logic lb, input logic [7:0] sb);
        int lat;
        loopback   = lb;
        slave_byte = sb;
        fall_base  = fall_cnt;
        model_rx   = lb ? tx : sb;
        tx_q.push_back(tx);
        access(2'd0, 1'b1, {24'd0, tx}, 32'd0, lat);
    endtask

    // Watchdog so a hung design still produces a verdict.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios, then randomized transfers, then abort recovery.
    initial begin
        int lat;
        int rb;
        logic [7:0] tx;
        logic [7:0] sb;
        logic lb;
        int d;
        bus.cs = 1'b0;
        bus.bus_addr = 32'd0;
        bus.bus_wr_val = 32'd0;
        bus.bus_bytesel = 4'h0;
        model_div  = 99;
        model_cs_n = 1'b1;
        model_rx   = 8'hFF;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sclk", {31'd0, sd_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, sd_mosi}, 32'd1);
        chk("rst_cs_n", {31'd0, sd_cs_n}, 32'd1);
        chk("rst_ack", {31'd0, bus.bus_ack}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(2'd1, 1'b0, 32'd0, 32'h1, lat);
        access(2'd2, 1'b0, 32'd0, 32'd99, lat);
        access(2'd3, 1'b1, 32'hFFFF_FFFF, 32'd0, lat);
        access(2'd3, 1'b0, 32'd0, 32'd0, lat);
        access(2'd0, 1'b0, 32'd0, 32'h0000_00FF, lat);

        // Loopback at the fastest clock.
        access(2'd2, 1'b1, 32'd0, 32'd0, lat);
        model_div = 0;
        start_xfer(8'hA5, 1'b1, 8'h00);
        access(2'd0, 1'b0, 32'd0, {24'd0, model_rx}, lat);

        // MISO held low with CLKDIV=3.
        access(2'd2, 1'b1, 32'd3, 32'd0, lat);
        model_div = 3;
        start_xfer(8'hFF, 1'b0, 8'h00);
        access(2'd0, 1'b0, 32'd0, {24'd0, model_rx}, lat);
        chk("stall_lat_div3", 32'(lat >= 60), 32'd1);

        // A DATA read issued straight after a DATA write waits for the transfer to finish.
        access(2'd2, 1'b1, 32'd1, 32'd0, lat);
        model_div = 1;
        start_xfer(8'h3C, 1'b1, 8'h00);
        access(2'd0, 1'b0, 32'd0, {24'd0, model_rx}, lat);
        chk("stall_lat", 32'(lat >= 28), 32'd1);

        // Poll status mid-transfer, then a CTRL write that has to wait.
        rb = rise_cnt;
        start_xfer(8'h96, 1'b1, 8'h00);
        access(2'd1, 1'b0, 32'd0, {30'd0, 1'b1, model_cs_n}, lat);
        chk("poll_lat", 32'(lat <= 2), 32'd1);
        access(2'd1, 1'b1, 32'd0, 32'd0, lat);
        model_cs_n = 1'b0;
        chk("ctrl_wr_after_byte", 32'(rise_cnt - rb), 32'd8);
        chk("cs_n_low", {31'd0, sd_cs_n}, 32'd0);
        access(2'd1, 1'b0, 32'd0, {30'd0, 1'b0, model_cs_n}, lat);
        access(2'd0, 1'b0, 32'd0, {24'd0, model_rx}, lat);

        // Randomized transfers.
        for (int i = 0; i < 8; i++) begin
            d  = int'($urandom_range(0, 3));
            tx = 8'($urandom);
            sb = 8'($urandom);
            lb = 1'($urandom_range(0, 1));
            access(2'd2, 1'b1, 32'(d), 32'd0, lat);
            model_div = d;
            access(2'd2, 1'b0, 32'd0, 32'(d), lat);
            start_xfer(tx, lb, sb);
            if (i % 2 == 0) access(2'd1, 1'b0, 32'd0, {30'd0, 1'b1, model_cs_n}, lat);
            access(2'd0, 1'b0, 32'd0, {24'd0, model_rx}, lat);
            access(2'd1, 1'b0, 32'd0, {30'd0, 1'b0, model_cs_n}, lat);
        end

        // Abort a transfer with reset, then recover.
        access(2'd2, 1'b1, 32'd3, 32'd0, lat);
        model_div = 3;
        start_xfer(8'hC3, 1'b1, 8'h00);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_sclk", {31'd0, sd_sclk}, 32'd0);
        chk("abort_mosi", {31'd0, sd_mosi}, 32'd1);
        chk("abort_cs_n", {31'd0, sd_cs_n}, 32'd1);
        chk("abort_ack", {31'd0, bus.bus_ack}, 32'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        model_div  = 99;
        model_cs_n = 1'b1;
        model_rx   = 8'hFF;
        access(2'd1, 1'b0, 32'd0, 32'h1, lat);
        access(2'd0, 1'b0, 32'd0, 32'h0000_00FF, lat);
        access(2'd2, 1'b1, 32'd0, 32'd0, lat);
        model_div = 0;
        start_xfer(8'h55, 1'b1, 8'h00);
        access(2'd0, 1'b0, 32'd0, {24'd0, model_rx}, lat);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("tx_queue_empty", 32'(tx_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
